// File: rtl/sha256_pkg.sv
// Shared SHA-256 types: block layout, padding constants and padder states.
package sha256_pkg;

   localparam int BLOCK_BITS      = 512;
   localparam int BLOCK_BYTES     = 64;
   localparam int LEN_FIELD_BYTES = 8;
   localparam int LAST_DATA_BYTE  = 55;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef logic [0:BLOCK_BITS-1] block_t;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_EMIT,
      ST_EMIT_LAST,
      ST_LEN_ONLY
   } pad_state_t;

endpackage

// File: rtl/sha256_msg_padder.sv
// Byte-stream to padded 512-bit block feeder for the SHA-256 core.
// Define SHA256_PAD_OVF_EN to add the sticky len_ovf length-overflow output.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int LEN_BITS = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   input  logic         in_empty,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [0:511] blk_data,
   output logic         blk_first,
   output logic         blk_last
`ifdef SHA256_PAD_OVF_EN
   ,
   output logic         len_ovf
`endif
);

   pad_state_t          r_state, w_nstate;
   block_t              r_buf, w_nbuf;
   logic [6:0]          r_ptr, w_nptr;
   logic [LEN_BITS-1:0] r_bit_cnt, w_ncnt;
   logic                r_first_pend, w_nfp;
   logic                r_pend, w_npend;
   logic                r_pend80, w_np80;
   logic                r_blk_first, w_nbf;
   logic                r_blk_last, w_nbl;

   logic                w_wr;
   logic [6:0]          w_p;
   logic [LEN_BITS-1:0] w_cnt;
   logic                w_put80;
   logic                w_putlen;

   function automatic block_t f_build(
      input block_t      b,
      input logic [6:0]  wptr,
      input logic [7:0]  d,
      input logic        wr,
      input logic [6:0]  pptr,
      input logic        put80,
      input logic        putlen,
      input logic [63:0] len
   );
      block_t r;
      r = b;
      for (int k = 0; k < BLOCK_BYTES; k++) begin
         if (wr && wptr == 7'(k))
            r[8*k +: 8] = d;
         if (put80 && pptr == 7'(k))
            r[8*k +: 8] = PAD_BYTE;
      end
      // Length field is big-endian in the final eight bytes.
      if (putlen)
         for (int j = 0; j < LEN_FIELD_BYTES; j++)
            r[8*(BLOCK_BYTES-LEN_FIELD_BYTES+j) +: 8] =
               len[8*(LEN_FIELD_BYTES-1-j) +: 8];
      return r;
   endfunction

   assign in_ready  = (r_state == ST_FILL);
   assign blk_valid = (r_state == ST_EMIT) || (r_state == ST_EMIT_LAST);
   assign blk_data  = r_buf;
   assign blk_first = r_blk_first;
   assign blk_last  = r_blk_last;

   always_comb begin
      w_nstate = r_state;
      w_nbuf   = r_buf;
      w_nptr   = r_ptr;
      w_ncnt   = r_bit_cnt;
      w_nfp    = r_first_pend;
      w_npend  = r_pend;
      w_np80   = r_pend80;
      w_nbf    = r_blk_first;
      w_nbl    = r_blk_last;
      w_wr     = 1'b0;
      w_p      = r_ptr;
      w_cnt    = r_bit_cnt;
      w_put80  = 1'b0;
      w_putlen = 1'b0;
      unique case (r_state)
         ST_FILL: begin
            if (in_valid) begin
               w_wr     = !(in_last && in_empty);
               w_p      = r_ptr + 7'(w_wr);
               w_cnt    = w_wr ? r_bit_cnt + LEN_BITS'(8) : r_bit_cnt;
               w_put80  = in_last && (w_p < 7'(BLOCK_BYTES));
               w_putlen = in_last && (w_p <= 7'(LAST_DATA_BYTE));
               w_nbuf   = f_build(r_buf, r_ptr, in_data, w_wr, w_p,
                                  w_put80, w_putlen, 64'(w_cnt));
               w_nptr   = w_p;
               w_ncnt   = w_cnt;
               if (w_putlen) begin
                  w_nstate = ST_EMIT_LAST;
                  w_nbf    = r_first_pend;
                  w_nbl    = 1'b1;
               end else if (in_last) begin
                  w_nstate = ST_EMIT;
                  w_npend  = 1'b1;
                  w_np80   = !w_put80;
                  w_nbf    = r_first_pend;
                  w_nbl    = 1'b0;
               end else if (w_p == 7'(BLOCK_BYTES)) begin
                  w_nstate = ST_EMIT;
                  w_nbf    = r_first_pend;
                  w_nbl    = 1'b0;
               end
            end
         end
         ST_EMIT, ST_EMIT_LAST: begin
            if (blk_ready) begin
               w_nbuf = '0;
               w_nptr = '0;
               w_nfp  = 1'b0;
               w_nbf  = 1'b0;
               w_nbl  = 1'b0;
               if (r_state == ST_EMIT_LAST) begin
                  w_nstate = ST_FILL;
                  w_nfp    = 1'b1;
                  w_ncnt   = '0;
               end else if (r_pend) begin
                  w_nstate = ST_LEN_ONLY;
               end else begin
                  w_nstate = ST_FILL;
               end
            end
         end
         ST_LEN_ONLY: begin
            w_nbuf   = f_build('0, 7'd0, 8'd0, 1'b0, 7'd0,
                               r_pend80, 1'b1, 64'(r_bit_cnt));
            w_npend  = 1'b0;
            w_np80   = 1'b0;
            w_nbf    = r_first_pend;
            w_nbl    = 1'b1;
            w_nstate = ST_EMIT_LAST;
         end
         default: w_nstate = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_FILL;
         r_buf        <= '0;
         r_ptr        <= '0;
         r_bit_cnt    <= '0;
         r_first_pend <= 1'b1;
         r_pend       <= 1'b0;
         r_pend80     <= 1'b0;
         r_blk_first  <= 1'b0;
         r_blk_last   <= 1'b0;
      end else begin
         r_state      <= w_nstate;
         r_buf        <= w_nbuf;
         r_ptr        <= w_nptr;
         r_bit_cnt    <= w_ncnt;
         r_first_pend <= w_nfp;
         r_pend       <= w_npend;
         r_pend80     <= w_np80;
         r_blk_first  <= w_nbf;
         r_blk_last   <= w_nbl;
      end
   end

`ifdef SHA256_PAD_OVF_EN
   logic r_len_ovf;
   logic w_ovf_hit;

   // Adding a byte at or above 2^LEN_BITS-8 wraps the count.
   assign w_ovf_hit = (r_state == ST_FILL) && in_valid && w_wr &&
                      (&r_bit_cnt[LEN_BITS-1:3]);

   always_ff @(posedge clk) begin
      if (reset)
         r_len_ovf <= 1'b0;
      else if (w_ovf_hit)
         r_len_ovf <= 1'b1;
   end

   assign len_ovf = r_len_ovf;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;
   import sha256_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_empty;
   logic         blk_valid;
   logic         blk_ready;
   logic [0:511] blk_data;
   logic         blk_first;
   logic         blk_last;
`ifdef SHA256_PAD_OVF_EN
   logic         len_ovf;
`endif

   int checks = 0;
   int failures = 0;

   block_t rx[$];

   sha256_msg_padder #(.LEN_BITS(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_empty  (in_empty),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last)
`ifdef SHA256_PAD_OVF_EN
      ,
      .len_ovf   (len_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pads per FIPS 180-4 at byte level, then drives/collects the DUT.
   task automatic run_msg(input byte unsigned m[$], input bit empty,
                          input bit rnd, input bit stall5);
      block_t       exp_b[$];
      byte unsigned pb[$];
      logic [63:0]  len;
      block_t       b, pd;
      logic         pf, pl, pv, acc, hs;
      int           nexp, idx, got, cyc, st;
      pb = m;
      pb.push_back(8'h80);
      while (pb.size() % 64 != 56) pb.push_back(8'h00);
      len = 64'(m.size()) * 64'd8;
      for (int j = 7; j >= 0; j--) pb.push_back(len[8*j +: 8]);
      nexp = pb.size() / 64;
      for (int bi = 0; bi < nexp; bi++) begin
         b = '0;
         for (int k = 0; k < 64; k++) b[8*k +: 8] = pb[64*bi + k];
         exp_b.push_back(b);
      end
      rx.delete();
      idx = 0; got = 0; cyc = 0; st = 0; pv = 1'b0;
      pd = '0; pf = 1'b0; pl = 1'b0;
      while (got < nexp && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         in_data  = 8'($urandom);
         in_valid = 1'b0;
         in_last  = 1'b0;
         in_empty = 1'b0;
         if (idx < m.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_data  = m[idx];
            in_last  = (idx == m.size() - 1);
         end else if (empty && idx == 0 &&
                      (!rnd || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_empty = 1'b1;
         end
         blk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (stall5 && blk_valid && st < 5) begin
            blk_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'hff;
            in_last   = 1'b0;
            in_empty  = 1'b0;
            chk("stall_in_ready", 512'(in_ready), 512'(0));
            st++;
         end
         if (pv) begin
            chk("stable_data", blk_data, pd);
            chk("stable_flags", 512'({blk_valid, blk_first, blk_last}),
                512'({1'b1, pf, pl}));
         end
         pv  = blk_valid && !blk_ready;
         pd  = blk_data;
         pf  = blk_first;
         pl  = blk_last;
         acc = in_valid && in_ready;
         hs  = blk_valid && blk_ready;
         if (hs) begin
            chk("blk_data", blk_data, exp_b[got]);
            chk("blk_first", 512'(blk_first), 512'(got == 0));
            chk("blk_last", 512'(blk_last), 512'(got == nexp - 1));
            rx.push_back(blk_data);
            got++;
         end
         @(posedge clk);
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_empty  = 1'b0;
      blk_ready = 1'b1;
      chk("n_blocks", 512'(got), 512'(nexp));
      @(negedge clk);
      chk("idle_after", 512'({blk_valid, in_ready}), 512'(2'b01));
   endtask

   initial begin
      byte unsigned m[$];
      block_t       b, abc_blk;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      in_empty  = 1'b0;
      blk_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", 512'(in_ready), 512'(1));
      chk("rst_blk_valid", 512'(blk_valid), 512'(0));
      chk("rst_blk_data", blk_data, 512'(0));
      chk("rst_flags", 512'({blk_first, blk_last}), 512'(0));

      m = '{8'h61, 8'h62, 8'h63};
      run_msg(m, 1'b0, 1'b0, 1'b0);
      b = rx.size() > 0 ? rx[0] : '0;
      abc_blk = b;
      chk("abc_word0", 512'(b[0:31]), 512'(32'h61626380));
      chk("abc_zero", 512'(b[32:503]), 512'(0));
      chk("abc_len", 512'(b[504:511]), 512'(8'h18));

      m.delete();
      run_msg(m, 1'b1, 1'b0, 1'b0);
      b = rx.size() > 0 ? rx[0] : '0;
      chk("empty_b0", 512'(b[0:7]), 512'(8'h80));
      chk("empty_rest", 512'(b[8:511]), 512'(0));

      m.delete();
      for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
      run_msg(m, 1'b0, 1'b0, 1'b0);
      b = rx.size() > 0 ? rx[0] : '0;
      chk("m55_pad", 512'(b[440:447]), 512'(8'h80));
      chk("m55_len", 512'(b[448:511]), 512'(64'h1B8));

      m.push_back(8'($urandom));
      run_msg(m, 1'b0, 1'b0, 1'b0);
      chk("m56_nblk", 512'(rx.size()), 512'(2));
      b = rx.size() > 0 ? rx[0] : '0;
      chk("m56_pad", 512'(b[448:455]), 512'(8'h80));
      b = rx.size() > 1 ? rx[1] : '1;
      chk("m56_zero", 512'(b[0:447]), 512'(0));
      chk("m56_len", 512'(b[448:511]), 512'(64'h1C0));

      for (int i = 0; i < 8; i++) m.push_back(8'($urandom));
      run_msg(m, 1'b0, 1'b0, 1'b1);
      b = rx.size() > 1 ? rx[1] : '0;
      chk("m64_b0", 512'(b[0:7]), 512'(8'h80));
      chk("m64_len", 512'(b[448:511]), 512'(64'h200));

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_last  = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m = '{8'h61, 8'h62, 8'h63};
      run_msg(m, 1'b0, 1'b0, 1'b0);
      chk("rst_abc_nblk", 512'(rx.size()), 512'(1));
      b = rx.size() > 0 ? rx[0] : '0;
      chk("rst_abc_blk", b, abc_blk);

      for (int t = 0; t < 8; t++) begin
         int n;
         n = $urandom_range(0, 150);
         m.delete();
         for (int i = 0; i < n; i++) m.push_back(8'($urandom));
         run_msg(m, n == 0, 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
